// File: rtl/instruction_fetch_unit.sv
// Purpose : Fetch stage feeding Instruction_Memory. Owns the 64-bit PC, captures
//           the returned word into an IF/ID register with a valid/ready handshake,
//           and handles redirects, stalls, zero-word halt and misaligned targets.
// Ports   : clk, reset (async, active-high)
//           imem_addr/imem_instr       - memory address (= PC) and combinational read data
//           redirect_valid/_target     - taken branch/jump from execute
//           id_ready                   - decode accepts this cycle
//           if_valid/if_instr/if_pc    - IF/ID register outputs
//           halted, misaligned_err     - status (error is sticky until reset)
//           fetch_count                - instructions accepted by decode (wraps)
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [63:0]        imem_addr,
    input  logic [31:0]        imem_instr,
    input  logic               redirect_valid,
    input  logic [63:0]        redirect_target,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [63:0]        if_pc,
    output logic               halted,
    output logic               misaligned_err,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]         r_state;
    logic [63:0]        r_pc;
    logic               r_if_valid;
    logic [31:0]        r_if_instr;
    logic [63:0]        r_if_pc;
    logic               r_err;
    logic [COUNT_W-1:0] r_count;

    logic [0:0]         w_state_nxt;
    logic [63:0]        w_pc_nxt;
    logic               w_if_valid_nxt;
    logic [31:0]        w_if_instr_nxt;
    logic [63:0]        w_if_pc_nxt;
    logic               w_err_nxt;
    logic [COUNT_W-1:0] w_count_nxt;
    logic               w_xfer;
    logic               w_slot_free;

    assign w_xfer      = r_if_valid && id_ready;
    assign w_slot_free = !r_if_valid || id_ready;

    // Next-state and datapath: redirect > fetch/zero-halt > stall > halt drain
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = r_if_valid;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;
        w_err_nxt      = r_err;
        w_count_nxt    = r_count;

        // A handshake completing in a flush cycle still counts
        if (w_xfer) begin
            w_count_nxt = r_count + COUNT_W'(1);
        end

        if (redirect_valid) begin
            w_if_valid_nxt = 1'b0;
            if (redirect_target[1:0] == 2'b00) begin
                w_pc_nxt    = redirect_target;
                w_state_nxt = ST_RUN;
            end else begin
                w_err_nxt   = 1'b1;
                w_state_nxt = ST_HALT;
            end
        end else if (r_state == ST_RUN) begin
            if (w_slot_free) begin
                if (imem_instr != 32'd0) begin
                    w_if_instr_nxt = imem_instr;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + 64'd4;
                end else begin
                    // All-zero word: stop with pc parked on it
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = ST_HALT;
                end
            end
        end else begin
            if (w_xfer) begin
                w_if_valid_nxt = 1'b0;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_instr <= 32'd0;
            r_if_pc    <= 64'd0;
            r_err      <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_err      <= w_err_nxt;
            r_count    <= w_count_nxt;
        end
    end

    assign imem_addr      = r_pc;
    assign if_valid       = r_if_valid;
    assign if_instr       = r_if_instr;
    assign if_pc          = r_if_pc;
    assign halted         = (r_state == ST_HALT);
    assign misaligned_err = r_err;
    assign fetch_count    = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, async-reset sequence,
// and randomized run against a behavioural model.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        halted;
    logic        misaligned_err;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    instruction_fetch_unit #(.RESET_PC(64'd0), .COUNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_ready        (id_ready),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .halted          (halted),
        .misaligned_err  (misaligned_err),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image; the top 16 bytes of the address space hold nonzero words
    // so the random run can exercise PC wrap.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'd0) return 32'h00000033;
        if (a == 64'd4) return 32'h00A50533;
        if (a == 64'd8) return 32'h40058533;
        if (a >= 64'hFFFF_FFFF_FFFF_FFF0) return a[31:0] ^ 32'h0000_1013;
        return 32'h0;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic check(input string tag, input logic v, input logic [31:0] ins,
                         input logic [63:0] ipc, input logic h, input logic e,
                         input logic [63:0] addr, input logic [31:0] cnt);
        checks++;
        if (if_valid !== v || if_instr !== ins || if_pc !== ipc || halted !== h ||
            misaligned_err !== e || imem_addr !== addr || fetch_count !== cnt) begin
            errors++;
            $display("FAIL %s: got v=%0b instr=%h pc=%h halt=%0b err=%0b addr=%h cnt=%0d; want v=%0b instr=%h pc=%h halt=%0b err=%0b addr=%h cnt=%0d",
                     tag, if_valid, if_instr, if_pc, halted, misaligned_err, imem_addr, fetch_count,
                     v, ins, ipc, h, e, addr, cnt);
        end
    endtask

    typedef struct {
        logic        rv;
        logic [63:0] tgt;
        logic        rdy;
        logic        v;
        logic [31:0] ins;
        logic [63:0] ipc;
        logic        h;
        logic        e;
        logic [63:0] addr;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic rv, input logic [63:0] tgt, input logic rdy,
                                input logic v, input logic [31:0] ins, input logic [63:0] ipc,
                                input logic h, input logic e, input logic [63:0] addr,
                                input logic [31:0] cnt);
        vec_t r;
        r.rv = rv; r.tgt = tgt; r.rdy = rdy; r.v = v; r.ins = ins; r.ipc = ipc;
        r.h = h; r.e = e; r.addr = addr; r.cnt = cnt;
        return r;
    endfunction

    // Behavioural reference state
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_instr, m_cnt;
    logic        m_valid, m_halt, m_err;

    task automatic model_reset();
        m_pc = 64'd0; m_ipc = 64'd0; m_instr = 32'd0; m_cnt = 32'd0;
        m_valid = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step(input logic rv, input logic [63:0] tgt, input logic rdy);
        logic        accepted;
        logic [31:0] w;
        accepted = m_valid && rdy;
        if (accepted) m_cnt = m_cnt + 32'd1;
        if (rv) begin
            m_valid = 1'b0;
            if (tgt % 64'd4 == 64'd0) begin
                m_pc   = tgt;
                m_halt = 1'b0;
            end else begin
                m_err  = 1'b1;
                m_halt = 1'b1;
            end
        end else if (!m_halt) begin
            if (!m_valid || rdy) begin
                w = mem_word(m_pc);
                if (w != 32'd0) begin
                    m_instr = w;
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 64'd4;
                end else begin
                    m_valid = 1'b0;
                    m_halt  = 1'b1;
                end
            end
        end else if (accepted) begin
            m_valid = 1'b0;
        end
    endtask

    vec_t tbl[21];

    initial begin
        tbl[0]  = mk(0, 0, 1, 1, 32'h00000033, 0, 0, 0, 4,  0);
        tbl[1]  = mk(0, 0, 1, 1, 32'h00A50533, 4, 0, 0, 8,  1);
        tbl[2]  = mk(0, 0, 1, 1, 32'h40058533, 8, 0, 0, 12, 2);
        tbl[3]  = mk(0, 0, 1, 0, 32'h40058533, 8, 1, 0, 12, 3);
        tbl[4]  = mk(1, 4, 1, 0, 32'h40058533, 8, 0, 0, 4,  3);
        tbl[5]  = mk(0, 0, 1, 1, 32'h00A50533, 4, 0, 0, 8,  3);
        tbl[6]  = mk(0, 0, 0, 1, 32'h00A50533, 4, 0, 0, 8,  3);
        tbl[7]  = mk(0, 0, 0, 1, 32'h00A50533, 4, 0, 0, 8,  3);
        tbl[8]  = mk(0, 0, 0, 1, 32'h00A50533, 4, 0, 0, 8,  3);
        tbl[9]  = mk(0, 0, 1, 1, 32'h40058533, 8, 0, 0, 12, 4);
        tbl[10] = mk(0, 0, 1, 0, 32'h40058533, 8, 1, 0, 12, 5);
        tbl[11] = mk(1, 6, 1, 0, 32'h40058533, 8, 1, 1, 12, 5);
        tbl[12] = mk(1, 0, 1, 0, 32'h40058533, 8, 0, 1, 0,  5);
        tbl[13] = mk(0, 0, 1, 1, 32'h00000033, 0, 0, 1, 4,  5);
        tbl[14] = mk(1, 8, 0, 0, 32'h00000033, 0, 0, 1, 8,  5);
        tbl[15] = mk(0, 0, 1, 1, 32'h40058533, 8, 0, 1, 12, 5);
        tbl[16] = mk(0, 0, 1, 0, 32'h40058533, 8, 1, 1, 12, 6);
        tbl[17] = mk(1, 0, 1, 0, 32'h40058533, 8, 0, 1, 0,  6);
        tbl[18] = mk(0, 0, 1, 1, 32'h00000033, 0, 0, 1, 4,  6);
        tbl[19] = mk(1, 4, 1, 0, 32'h00000033, 0, 0, 1, 4,  7);
        tbl[20] = mk(0, 0, 1, 1, 32'h00A50533, 4, 0, 1, 8,  7);

        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_target = 64'd0;
        id_ready = 1'b1;
        #2;
        check("reset_state", 0, 32'd0, 64'd0, 0, 0, 64'd0, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 21; i++) begin
            redirect_valid  = tbl[i].rv;
            redirect_target = tbl[i].tgt;
            id_ready        = tbl[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tbl[i].v, tbl[i].ins, tbl[i].ipc, tbl[i].h,
                  tbl[i].e, tbl[i].addr, tbl[i].cnt);
        end

        // Async reset asserted mid-cycle during a stall
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        @(posedge clk);
        #1;
        check("stall_before_reset", 1, 32'h00A50533, 64'd4, 0, 1, 64'd8, 32'd7);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", 0, 32'd0, 64'd0, 0, 0, 64'd0, 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", 0, 32'd0, 64'd0, 0, 0, 64'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        id_ready = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_reset", 1, 32'h00000033, 64'd0, 0, 0, 64'd4, 32'd0);

        // Randomized run against the reference model
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic        rv;
            logic [63:0] tgt;
            logic        rdy;
            rv  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0: tgt = 64'd0;
                1: tgt = 64'd4;
                2: tgt = 64'd8;
                3: tgt = 64'd12;
                4: tgt = 64'd6;
                5: tgt = 64'hFFFF_FFFF_FFFF_FFF0;
                6: tgt = 64'hFFFF_FFFF_FFFF_FFF8;
                7: tgt = 64'hFFFF_FFFF_FFFF_FFFD;
                8: tgt = {32'd0, $urandom()};
                default: tgt = 64'hFFFF_FFFF_FFFF_FFF4;
            endcase
            redirect_valid  = rv;
            redirect_target = tgt;
            id_ready        = rdy;
            model_step(rv, tgt, rdy);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", c), m_valid, m_instr, m_ipc, m_halt, m_err, m_pc, m_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of Instruction_Memory.
- Owns the 64-bit program counter and drives the memory address.
- Captures the returned 32-bit word into an IF/ID output register with a valid/ready handshake to decode.
- Handles branch/jump redirects, back-pressure stalls, halt on an all-zero word, and misaligned-target errors.

Parameters:
- RESET_PC, 64'd0, PC value loaded on reset.
- COUNT_W, 32, width of delivered-instruction counter.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  64  address to Instruction_Memory; equals the PC register.
- imem_instr  input  32  combinational read data from Instruction_Memory (same cycle as imem_addr).
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_target  input  64  new PC when redirect_valid=1.
- id_ready  input  1  decode can accept an instruction this cycle.
- if_valid  output  1  if_instr/if_pc hold a valid instruction.
- if_instr  output  32  fetched instruction.
- if_pc  output  64  address of if_instr.
- halted  output  1  fetch stopped (state HALT).
- misaligned_err  output  1  sticky: a redirect target had target[1:0] != 0.
- fetch_count  output  COUNT_W  number of instructions accepted by decode.

Behaviour:
- Reset (async assert, takes effect immediately):
  - pc = RESET_PC; state = RUN.
  - if_valid = 0, if_instr = 0, if_pc = 0.
  - halted = 0, misaligned_err = 0, fetch_count = 0.
- imem_addr = pc at all times, combinational from the register.
- Handshake:
  - Transfer occurs when if_valid && id_ready.
  - slot_free = !if_valid || id_ready.
- States RUN, HALT. halted = (state == HALT).
- Per-cycle priority:
  1. redirect_valid=1: flush (if_valid<=0), regardless of id_ready or pending valid.
     - If redirect_target[1:0] == 0: pc <= redirect_target, state <= RUN (exits HALT).
     - Otherwise: misaligned_err <= 1, state <= HALT, pc unchanged.
     - A flushed instruction does not count unless its transfer handshake completed in that same cycle.
  2. RUN && slot_free && imem_instr != 0: if_instr <= imem_instr, if_pc <= pc, if_valid <= 1, pc <= pc + 4.
  3. RUN && slot_free && imem_instr == 0: no capture; if_valid <= 0; state <= HALT; pc holds at the zero-word address.
  4. RUN && !slot_free (stall): if_valid, if_instr, if_pc and pc all hold.
  5. HALT: no fetch, pc holds. A pending if_valid still drains and clears on handshake.
- fetch_count increments by 1 on every transfer handshake. It wraps modulo 2^COUNT_W.
- pc + 4 wraps modulo 2^64. No error on wrap.
- Latency:
  - Reset release to first if_valid = 1 cycle.
  - Redirect to first valid instruction from the target = 1 cycle after the redirect edge.
  - Throughput is one instruction per cycle with id_ready held high.
- misaligned_err clears only on reset. A later aligned redirect leaves HALT but keeps the flag set.
- Reset mid-stall or mid-redirect: all state returns immediately to reset values. No partial capture survives.

Test Plan:
Memory image for all scenarios: 0:32'h00000033, 4:32'h00A50533, 8:32'h40058533, 12 and above: 32'h0.
1. Release reset, id_ready=1 constant:
   - Edge 1: if_valid=1, if_instr=00000033, if_pc=0.
   - Edge 2: 00A50533 / 4.
   - Edge 3: 40058533 / 8.
   - Edge 4: if_valid=0, halted=1, imem_addr=12, fetch_count=3.
2. Stall: hold id_ready=0 for 3 cycles while if_instr=00A50533 / if_pc=4.
   - Outputs stay stable and imem_addr stays 8.
   - On id_ready=1, the next edge shows 40058533 / 8 and fetch_count increments once.
3. While halted at pc=12, pulse redirect_valid with target=4:
   - Next edge: halted=0, if_valid=0, pc=4.
   - Following edge: if_instr=00A50533, if_pc=4.
4. Redirect to target=64'h6:
   - misaligned_err=1, halted=1, if_valid=0, pc unchanged.
   - A subsequent redirect to 0 resumes fetch of 00000033 with misaligned_err still 1.
5. Pending if_valid=1 with id_ready=0, and redirect_valid=1 to target 8 in the same cycle:
   - The instruction is flushed (fetch_count unchanged).
   - The next valid instruction is 40058533 / 8.
6. Assert reset asynchronously mid-cycle during a stall:
   - if_valid, if_instr, if_pc, halted, misaligned_err and fetch_count go to 0 and imem_addr=RESET_PC before the next clock edge.
